// File: rtl/exu_arbiter_if.sv
// rtl/exu_arbiter_if.sv - requester and execution-unit handshake bundle for exu_arbiter
interface exu_arbiter_if;
    logic        r0_req;
    logic [19:0] r0_sig;
    logic [31:0] r0_src1;
    logic [31:0] r0_src2;
    logic        r1_req;
    logic [19:0] r1_sig;
    logic [31:0] r1_src1;
    logic [31:0] r1_src2;
    logic        r0_gnt;
    logic        r1_gnt;
    logic        r0_done;
    logic        r1_done;
    logic [31:0] r_result;
    logic [2:0]  r_exception;
    logic [19:0] ex_sig;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic        ex_out_valid;
    logic [31:0] ex_result;
    logic [2:0]  ex_exception;
    logic        ex_in_valid;
    logic        busy;

    modport master (
        input  r0_req, r0_sig, r0_src1, r0_src2,
        input  r1_req, r1_sig, r1_src1, r1_src2,
        input  ex_result, ex_exception, ex_in_valid,
        output r0_gnt, r1_gnt, r0_done, r1_done, r_result, r_exception,
        output ex_sig, ex_src1, ex_src2, ex_out_valid, busy
    );

    modport slave (
        output r0_req, r0_sig, r0_src1, r0_src2,
        output r1_req, r1_sig, r1_src1, r1_src2,
        output ex_result, ex_exception, ex_in_valid,
        input  r0_gnt, r1_gnt, r0_done, r1_done, r_result, r_exception,
        input  ex_sig, ex_src1, ex_src2, ex_out_valid, busy
    );
endinterface

// File: rtl/exu_arbiter.sv
// rtl/exu_arbiter.sv - two-requester round-robin arbiter in front of a single execution unit
// Optional WAIT watchdog enabled by defining EXU_ARB_TIMEOUT_EN (abort after TIMEOUT cycles).
module exu_arbiter #(
    parameter int TIMEOUT = 127
) (
    input  logic          clk,
    input  logic          rstn,
    exu_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_win;
    logic        r_gnt_stb;
    logic [19:0] r_sig;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [31:0] r_res;
    logic [2:0]  r_exc;

    logic        w_any;
    logic        w_pick;
    logic [19:0] w_sel_sig;
    logic        w_illegal;
    logic        w_timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("exu_arbiter: TIMEOUT must be at least 1");
    end

    assign w_any     = bus.r0_req | bus.r1_req;
    // r_last=1 means r1 won last time, so r0 gets the tie
    assign w_pick    = (bus.r0_req & bus.r1_req) ? ~r_last : bus.r1_req;
    assign w_sel_sig = w_pick ? bus.r1_sig : bus.r0_sig;
    assign w_illegal = (w_sel_sig[16:0] == 17'd0);

`ifdef EXU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wait_cnt == CW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.ex_in_valid || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_win     <= 1'b0;
            r_gnt_stb <= 1'b0;
            r_sig     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_res     <= '0;
            r_exc     <= '0;
        end else begin
            r_state   <= w_next;
            r_gnt_stb <= (r_state == S_IDLE) && w_any;
            if (r_state == S_IDLE && w_any) begin
                r_win  <= w_pick;
                r_last <= w_pick;
                r_sig  <= w_sel_sig;
                r_src1 <= w_pick ? bus.r1_src1 : bus.r0_src1;
                r_src2 <= w_pick ? bus.r1_src2 : bus.r0_src2;
                if (w_illegal) begin
                    r_res <= '0;
                    r_exc <= 3'b001;
                end
            end
            if (r_state == S_WAIT) begin
                if (bus.ex_in_valid) begin
                    r_res <= bus.ex_result;
                    r_exc <= bus.ex_exception;
                end else if (w_timeout) begin
                    r_res <= '0;
                    r_exc <= 3'b111;
                end
            end
        end
    end

    // grant strobe lands on ISSUE, or on RESP for an illegal op
    assign bus.r0_gnt       = r_gnt_stb & ~r_win;
    assign bus.r1_gnt       = r_gnt_stb &  r_win;
    assign bus.r0_done      = (r_state == S_RESP) & ~r_win;
    assign bus.r1_done      = (r_state == S_RESP) &  r_win;
    assign bus.r_result     = r_res;
    assign bus.r_exception  = r_exc;
    assign bus.ex_sig       = r_sig;
    assign bus.ex_src1      = r_src1;
    assign bus.ex_src2      = r_src2;
    assign bus.ex_out_valid = (r_state == S_ISSUE);
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_exu_arbiter.sv
// tb/tb_exu_arbiter.sv - directed self-checking bench for exu_arbiter
module tb_exu_arbiter;
    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;
    int   n_issue;
    int   n_clash;
    int   who;
    int   base;

    exu_arbiter_if u_if ();

`ifdef EXU_ARB_TIMEOUT_EN
    exu_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rstn(rstn), .bus(u_if));
`else
    exu_arbiter dut (.clk(clk), .rstn(rstn), .bus(u_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.ex_out_valid) n_issue++;
        if ((u_if.r0_gnt && u_if.r1_gnt) || (u_if.r0_done && u_if.r1_done)) n_clash++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input logic [31:0] res, input bit drop, output int w);
        w = -1;
        for (int k = 0; k < 10 && w < 0; k++) begin
            step();
            if (u_if.r0_gnt) w = 0;
            else if (u_if.r1_gnt) w = 1;
        end
        chk("gnt_seen", 32'(w >= 0), 32'd1);
        chk("issue_with_gnt", 32'(u_if.ex_out_valid), 32'd1);
        if (drop) begin
            u_if.r0_req = 1'b0;
            u_if.r1_req = 1'b0;
        end
        step();
        u_if.ex_result    = res;
        u_if.ex_exception = 3'b000;
        u_if.ex_in_valid  = 1'b1;
        step();
        u_if.ex_in_valid  = 1'b0;
        chk("done0", 32'(u_if.r0_done), 32'(w == 0));
        chk("done1", 32'(u_if.r1_done), 32'(w == 1));
        chk("result", u_if.r_result, res);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(u_if.busy), 32'd0);
        chk({tag, "_gnt"}, 32'({u_if.r0_gnt, u_if.r1_gnt}), 32'd0);
        chk({tag, "_done"}, 32'({u_if.r0_done, u_if.r1_done}), 32'd0);
        chk({tag, "_exv"}, 32'(u_if.ex_out_valid), 32'd0);
        chk({tag, "_res"}, u_if.r_result, 32'd0);
        chk({tag, "_exc"}, 32'(u_if.r_exception), 32'd0);
        chk({tag, "_sig"}, 32'(u_if.ex_sig), 32'd0);
        chk({tag, "_src"}, u_if.ex_src1 | u_if.ex_src2, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_issue = 0; n_clash = 0;
        rstn = 1'b0;
        u_if.r0_req = 1'b0; u_if.r0_sig = '0; u_if.r0_src1 = '0; u_if.r0_src2 = '0;
        u_if.r1_req = 1'b0; u_if.r1_sig = '0; u_if.r1_src1 = '0; u_if.r1_src2 = '0;
        u_if.ex_result = '0; u_if.ex_exception = '0; u_if.ex_in_valid = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rstn = 1'b1;
        step();

        // single op from r0, stub answers two cycles after issue
        u_if.r0_req = 1'b1; u_if.r0_sig = 20'h00001; u_if.r0_src1 = 32'd6; u_if.r0_src2 = 32'd7;
        step();
        chk("t1_gnt0", 32'(u_if.r0_gnt), 32'd1);
        chk("t1_exv", 32'(u_if.ex_out_valid), 32'd1);
        chk("t1_sig", 32'(u_if.ex_sig), 32'h1);
        chk("t1_src1", u_if.ex_src1, 32'd6);
        chk("t1_src2", u_if.ex_src2, 32'd7);
        u_if.r0_req = 1'b0;
        step();
        chk("t1_exv_off", 32'(u_if.ex_out_valid), 32'd0);
        chk("t1_busy", 32'(u_if.busy), 32'd1);
        u_if.ex_result = 32'd42; u_if.ex_exception = 3'b000; u_if.ex_in_valid = 1'b1;
        step();
        u_if.ex_in_valid = 1'b0;
        chk("t1_done0", 32'(u_if.r0_done), 32'd1);
        chk("t1_done1", 32'(u_if.r1_done), 32'd0);
        chk("t1_res", u_if.r_result, 32'd42);
        chk("t1_exc", 32'(u_if.r_exception), 32'd0);
        step();
        chk("t1_idle", 32'(u_if.busy), 32'd0);
        chk("t1_done_off", 32'(u_if.r0_done), 32'd0);
        chk("t1_hold", u_if.r_result, 32'd42);
        chk("t1_issues", 32'(n_issue), 32'd1);

        // back-to-back contention from reset: r0, r1, r0
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        base = n_issue;
        u_if.r0_req = 1'b1; u_if.r0_sig = 20'h00002; u_if.r0_src1 = 32'd10; u_if.r0_src2 = 32'd11;
        u_if.r1_req = 1'b1; u_if.r1_sig = 20'h00004; u_if.r1_src1 = 32'd20; u_if.r1_src2 = 32'd21;
        serve(32'd100, 1'b0, who);
        chk("rr_first", 32'(who), 32'd0);
        serve(32'd200, 1'b0, who);
        chk("rr_second", 32'(who), 32'd1);
        serve(32'd300, 1'b1, who);
        chk("rr_third", 32'(who), 32'd0);
        chk("rr_issues", 32'(n_issue - base), 32'd3);

        // illegal op from r1 bypasses the execution unit
        base = n_issue;
        u_if.r1_req = 1'b1; u_if.r1_sig = 20'h00000;
        step();
        u_if.r1_req = 1'b0;
        chk("ill_gnt1", 32'(u_if.r1_gnt), 32'd1);
        chk("ill_done1", 32'(u_if.r1_done), 32'd1);
        chk("ill_done0", 32'(u_if.r0_done), 32'd0);
        chk("ill_res", u_if.r_result, 32'd0);
        chk("ill_exc", 32'(u_if.r_exception), 32'b001);
        step();
        chk("ill_idle", 32'(u_if.busy), 32'd0);
        chk("ill_no_issue", 32'(n_issue - base), 32'd0);

        // spurious completion in IDLE, then reset mid-WAIT
        u_if.ex_result = 32'd99; u_if.ex_exception = 3'b101; u_if.ex_in_valid = 1'b1;
        step();
        u_if.ex_in_valid = 1'b0;
        chk("spur_busy", 32'(u_if.busy), 32'd0);
        chk("spur_res", u_if.r_result, 32'd0);
        chk("spur_exc", 32'(u_if.r_exception), 32'b001);
        u_if.r0_req = 1'b1; u_if.r0_sig = 20'h00004; u_if.r0_src1 = 32'd1; u_if.r0_src2 = 32'd2;
        step();
        chk("rst_gnt0", 32'(u_if.r0_gnt), 32'd1);
        u_if.r0_req = 1'b0;
        step();
        chk("rst_in_wait", 32'(u_if.busy), 32'd1);
        rstn = 1'b0;
        step();
        check_all_zero("midreset");
        rstn = 1'b1;
        u_if.ex_result = 32'd77; u_if.ex_in_valid = 1'b1;
        step();
        u_if.ex_in_valid = 1'b0;
        check_all_zero("late_exv");
        u_if.r1_req = 1'b1; u_if.r1_sig = 20'h00008; u_if.r1_src1 = 32'd3; u_if.r1_src2 = 32'd4;
        serve(32'd55, 1'b1, who);
        chk("post_rst_who", 32'(who), 32'd1);

        // unanswered issue: watchdog abort, or indefinite WAIT
        u_if.r0_req = 1'b1; u_if.r0_sig = 20'h00001;
        step();
        u_if.r0_req = 1'b0;
`ifdef EXU_ARB_TIMEOUT_EN
        repeat (8) step();
        chk("to_busy", 32'(u_if.busy), 32'd1);
        chk("to_early", 32'(u_if.r0_done), 32'd0);
        step();
        chk("to_done", 32'(u_if.r0_done), 32'd1);
        chk("to_res", u_if.r_result, 32'd0);
        chk("to_exc", 32'(u_if.r_exception), 32'b111);
        step();
`else
        repeat (20) step();
        chk("hang_busy", 32'(u_if.busy), 32'd1);
        chk("hang_done", 32'({u_if.r0_done, u_if.r1_done}), 32'd0);
        chk("hang_res", u_if.r_result, 32'd55);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
`endif
        chk("end_idle", 32'(u_if.busy), 32'd0);
        chk("no_clash", 32'(n_clash), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
